// File: rtl/mmio_vga_pkg.sv
// ============================================================================
// Module  : mmio_vga_pkg
// Purpose : VGA 640x480@60 timing, cell geometry and palette for mmio_vga.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mmio_vga_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    // Cells are 20 px wide and 15 lines tall; sub-counters stop at these values.
    localparam logic [4:0] CELL_W_LAST  = 5'd19;
    localparam logic [3:0] CELL_H_LAST  = 4'd14;

    localparam logic [15:0] FB_BASE_DEFAULT  = 16'h0200;
    localparam int          FB_DEPTH_DEFAULT = 1024;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'hFFFFFF, 24'h880000, 24'hAAFFEE,
        24'hCC44CC, 24'h00CC55, 24'h0000AA, 24'hEEEE77,
        24'hDD8855, 24'h664400, 24'hFF7777, 24'h333333,
        24'h777777, 24'hAAFF66, 24'h0088FF, 24'hBBBBBB
    };

    function automatic logic [9:0] expand8(input logic [7:0] c);
        return {c, c[7:6]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_vga_timing.sv
// ============================================================================
// Module  : vga_timing
// Purpose : Pixel enable, h/v counters, divider-free cell index and raw syncs.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_timing
    import mmio_vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_pix_en,
    output logic [9:0] o_cell_idx,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_visible
);

    logic       r_pix_en;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [4:0] r_hsub;
    logic [4:0] r_hcell;
    logic [3:0] r_vsub;
    logic [4:0] r_vcell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_en <= 1'b0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsub   <= 5'd0;
            r_hcell  <= 5'd0;
            r_vsub   <= 4'd0;
            r_vcell  <= 5'd0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_hcount == H_LAST) begin
                    r_hcount <= 10'd0;
                    r_hsub   <= 5'd0;
                    r_hcell  <= 5'd0;
                    if (r_vcount == V_LAST) begin
                        r_vcount <= 10'd0;
                        r_vsub   <= 4'd0;
                        r_vcell  <= 5'd0;
                    end else begin
                        r_vcount <= r_vcount + 10'd1;
                        if (r_vsub == CELL_H_LAST) begin
                            r_vsub  <= 4'd0;
                            r_vcell <= r_vcell + 5'd1;
                        end else begin
                            r_vsub  <= r_vsub + 4'd1;
                        end
                    end
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                    // Cell columns beyond 31 only occur in blanking and are never displayed.
                    if (r_hsub == CELL_W_LAST) begin
                        r_hsub  <= 5'd0;
                        r_hcell <= r_hcell + 5'd1;
                    end else begin
                        r_hsub  <= r_hsub + 5'd1;
                    end
                end
            end
        end
    end

    assign o_pix_en   = r_pix_en;
    assign o_cell_idx = {r_vcell, r_hcell};
    assign o_hs       = !((r_hcount >= H_SYNC_START) && (r_hcount < H_SYNC_END));
    assign o_vs       = !((r_vcount >= V_SYNC_START) && (r_vcount < V_SYNC_END));
    assign o_visible  = (r_hcount < H_VISIBLE) && (r_vcount < V_VISIBLE);

endmodule

`default_nettype wire

// File: rtl/mmio_vga.sv
// ============================================================================
// Module  : mmio_vga
// Purpose : Memory-mapped 32x32 colour framebuffer with VGA 640x480 scanout.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mmio_vga
    import mmio_vga_pkg::*;
#(
    parameter logic [15:0] FB_BASE  = FB_BASE_DEFAULT,
    parameter int          FB_DEPTH = FB_DEPTH_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        nreset,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic        rw,
    output logic [7:0]  vga_data,
    output logic [9:0]  rd_addr,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_BLANK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_SYNC
);

    localparam logic [15:0] c_fb_depth = 16'(FB_DEPTH);

    logic [7:0]  r_fb [0:FB_DEPTH-1];
    logic [3:0]  r_scan_q;
    logic [7:0]  r_vga_data;
    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_vis_d;

    logic        w_pix_en;
    logic [9:0]  w_cell_idx;
    logic        w_hs;
    logic        w_vs;
    logic        w_visible;
    logic [15:0] w_off;
    logic        w_in_win;
    logic [9:0]  w_idx;
    logic        w_we;
    logic [23:0] w_rgb;

    vga_timing u_timing (
        .clk        (CLOCK_50),
        .rst_n      (nreset),
        .o_pix_en   (w_pix_en),
        .o_cell_idx (w_cell_idx),
        .o_hs       (w_hs),
        .o_vs       (w_vs),
        .o_visible  (w_visible)
    );

    assign w_off    = addr - FB_BASE;
    assign w_in_win = (addr >= FB_BASE) && (w_off < c_fb_depth);
    assign w_idx    = w_off[9:0];
    assign w_we     = ~rw & w_in_win;

    // Both ports read before write, so a colliding scan fetch returns the old byte.
    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_fb[w_idx] <= data;
        end
        if (w_pix_en) begin
            r_scan_q <= r_fb[w_cell_idx][3:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nreset) begin
        if (!nreset) begin
            r_vga_data <= 8'h00;
        end else begin
            r_vga_data <= w_in_win ? r_fb[w_idx] : 8'h00;
        end
    end

    // Syncs and blank are delayed one pixel to line up with the RAM read.
    always_ff @(posedge CLOCK_50 or negedge nreset) begin
        if (!nreset) begin
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
            r_vis_d <= 1'b0;
        end else if (w_pix_en) begin
            r_hs_d  <= w_hs;
            r_vs_d  <= w_vs;
            r_vis_d <= w_visible;
        end
    end

    assign w_rgb     = PALETTE[r_scan_q];

    assign VGA_R     = r_vis_d ? expand8(w_rgb[23:16]) : 10'd0;
    assign VGA_G     = r_vis_d ? expand8(w_rgb[15:8])  : 10'd0;
    assign VGA_B     = r_vis_d ? expand8(w_rgb[7:0])   : 10'd0;
    assign VGA_BLANK = r_vis_d;
    assign VGA_HS    = r_hs_d;
    assign VGA_VS    = r_vs_d;
    assign VGA_CLK   = w_pix_en;
    assign VGA_SYNC  = 1'b0;
    assign vga_data  = r_vga_data;
    assign rd_addr   = w_cell_idx;

endmodule

`default_nettype wire

// File: tb/tb_mmio_vga.sv
// ============================================================================
// Module  : tb_mmio_vga
// Purpose : Directed scoreboard bench for mmio_vga bus access and scanout.
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_vga;

    logic        CLOCK_50 = 1'b0;
    logic        nreset   = 1'b0;
    logic [15:0] addr     = 16'h0000;
    logic [7:0]  data     = 8'h00;
    logic        rw       = 1'b1;
    logic [7:0]  vga_data;
    logic [9:0]  rd_addr;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;
    logic        VGA_CLK;
    logic        VGA_BLANK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_SYNC;

    always #10 CLOCK_50 = ~CLOCK_50;

    mmio_vga dut (
        .CLOCK_50  (CLOCK_50),
        .nreset    (nreset),
        .addr      (addr),
        .data      (data),
        .rw        (rw),
        .vga_data  (vga_data),
        .rd_addr   (rd_addr),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .VGA_CLK   (VGA_CLK),
        .VGA_BLANK (VGA_BLANK),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .VGA_SYNC  (VGA_SYNC)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        edges++;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [29:0] model_rgb(input logic [7:0] v);
        logic [23:0] c;
        case (v[3:0])
            4'h0: c = 24'h000000;  4'h1: c = 24'hFFFFFF;
            4'h2: c = 24'h880000;  4'h3: c = 24'hAAFFEE;
            4'h4: c = 24'hCC44CC;  4'h5: c = 24'h00CC55;
            4'h6: c = 24'h0000AA;  4'h7: c = 24'hEEEE77;
            4'h8: c = 24'hDD8855;  4'h9: c = 24'h664400;
            4'hA: c = 24'hFF7777;  4'hB: c = 24'h333333;
            4'hC: c = 24'h777777;  4'hD: c = 24'hAAFF66;
            4'hE: c = 24'h0088FF;  default: c = 24'hBBBBBB;
        endcase
        return {c[23:16], c[23:22], c[15:8], c[15:14], c[7:0], c[7:6]};
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        data = d;
        rw   = 1'b0;
        tick();
        rw   = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        rw   = 1'b1;
        push(tag, {24'd0, exp});
        tick();
        pop_check({24'd0, vga_data});
    endtask

    // Pixel p = y*800+x reaches the pins on pixel-clock edge 2p+2 after reset release.
    task automatic check_pixel(input string tag, input int x, input int y,
                               input logic [7:0] v, input bit vis);
        int target;
        target = 2 * (y * 800 + x) + 2;
        if (edges > target) begin
            checks++;
            failures++;
            $error("FAIL %s_late: observed edge %0d required <= %0d", tag, edges, target);
        end
        while (edges < target) tick();
        push(tag, {2'b00, (vis ? model_rgb(v) : 30'd0)});
        pop_check({2'b00, VGA_R, VGA_G, VGA_B});
        push({tag, "_blank"}, {31'd0, vis});
        pop_check({31'd0, VGA_BLANK});
    endtask

    task automatic wait_hs(input logic lvl, input int limit, input string tag, input int exp_edge);
        int n;
        n = 0;
        while (VGA_HS !== lvl && n < limit) begin
            tick();
            n++;
        end
        push(tag, exp_edge);
        pop_check(edges);
    endtask

    initial begin
        repeat (3) tick();
        push("rst_hs", 1);       pop_check({31'd0, VGA_HS});
        push("rst_vs", 1);       pop_check({31'd0, VGA_VS});
        push("rst_blank", 0);    pop_check({31'd0, VGA_BLANK});
        push("rst_rgb", 0);      pop_check({2'b00, VGA_R, VGA_G, VGA_B});
        push("rst_vga_data", 0); pop_check({24'd0, vga_data});
        push("rst_rd_addr", 0);  pop_check({22'd0, rd_addr});
        push("rst_clk_sync", 0); pop_check({30'd0, VGA_CLK, VGA_SYNC});

        nreset = 1'b1;
        for (int i = 0; i < 1024; i++) bus_write(16'h0200 + 16'(i), 8'h00);
        bus_write(16'h0200, 8'h01);
        bus_write(16'h0202, 8'h05);
        bus_write(16'h021F, 8'hF1);
        bus_write(16'h0220, 8'h02);
        bus_write(16'h05FF, 8'h02);
        bus_write(16'h0600, 8'h07);
        bus_write(16'h01FF, 8'h07);

        bus_read("rd_0200", 16'h0200, 8'h01);
        bus_read("rd_0201", 16'h0201, 8'h00);
        bus_read("rd_0202", 16'h0202, 8'h05);
        bus_read("rd_021F", 16'h021F, 8'hF1);
        bus_read("rd_05FF", 16'h05FF, 8'h02);
        bus_read("rd_0600", 16'h0600, 8'h00);
        bus_read("rd_01FF", 16'h01FF, 8'h00);

        // Reset while HS is low must drive outputs back immediately.
        begin
            int n;
            n = 0;
            while (VGA_HS !== 1'b0 && n < 4000) begin
                tick();
                n++;
            end
        end
        nreset = 1'b0;
        #1;
        push("midrst_hs", 1);    pop_check({31'd0, VGA_HS});
        push("midrst_blank", 0); pop_check({31'd0, VGA_BLANK});
        push("midrst_rgb", 0);   pop_check({2'b00, VGA_R, VGA_G, VGA_B});
        push("midrst_rd", 0);    pop_check({22'd0, rd_addr});
        push("midrst_data", 0);  pop_check({24'd0, vga_data});
        repeat (2) tick();

        nreset = 1'b1;
        edges  = 0;
        tick();
        push("vga_clk_edge1", 1); pop_check({31'd0, VGA_CLK});

        check_pixel("px_x0_y0",    0, 0, 8'h01, 1'b1);
        check_pixel("px_x19_y0",  19, 0, 8'h01, 1'b1);
        check_pixel("px_x20_y0",  20, 0, 8'h00, 1'b1);
        check_pixel("px_x40_y0",  40, 0, 8'h05, 1'b1);
        push("rd_addr_x40", 2); pop_check({22'd0, rd_addr});
        check_pixel("px_x639_y0", 639, 0, 8'hF1, 1'b1);
        check_pixel("px_x640_y0", 640, 0, 8'h00, 1'b0);

        wait_hs(1'b0, 3000, "hs_first_fall", 1314);
        wait_hs(1'b1, 3000, "hs_rise", 1506);
        wait_hs(1'b0, 3000, "hs_period", 2914);

        check_pixel("px_x19_y14", 19, 14, 8'h01, 1'b1);
        check_pixel("px_x0_y15",   0, 15, 8'h02, 1'b1);
        push("rd_addr_y15", 32); pop_check({22'd0, rd_addr});
        bus_write(16'h0240, 8'h0E);
        wait_hs(1'b0, 3000, "hs_line15_fall", 25314);
        check_pixel("px_x0_y29",   0, 29, 8'h02, 1'b1);
        check_pixel("px_x0_y30",   0, 30, 8'h0E, 1'b1);
        check_pixel("px_x20_y30", 20, 30, 8'h00, 1'b1);
        push("vs_high", 1); pop_check({31'd0, VGA_VS});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
